// File: rtl/mesi_pkg.sv
// Shared definitions for the MESI bus controller and the per-line snoopers.
package mesi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BCAST = 3'd1,
    ST_SNOOP = 3'd2,
    ST_WB    = 3'd3,
    ST_MEM   = 3'd4,
    ST_DONE  = 3'd5
  } bus_state_t;

  // Bus events use the snooper CPU_event coding {inv,wh,wm,rh,rm}.
  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_INV  = 5'b10000;
  localparam logic [4:0] EV_WM   = 5'b00100;
  localparam logic [4:0] EV_RM   = 5'b00001;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RM   = 2'b01;
  localparam logic [1:0] OP_WM   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic [2:0] {
    LS_I = 3'b001,
    LS_S = 3'b010,
    LS_E = 3'b011,
    LS_M = 3'b100
  } line_state_t;

  function automatic logic [4:0] op_to_event(input logic [1:0] op);
    case (op)
      OP_RM:   return EV_RM;
      OP_WM:   return EV_WM;
      OP_INV:  return EV_INV;
      default: return EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mesi_bus_ctrl_arb.sv
// Combinational round-robin arbiter: first eligible index after ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic found;

  // Scan ptr+1 .. ptr+N (mod N); the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && eligible[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        index = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Shared-bus controller: round-robin grant, snoop broadcast, write-back and fill sequencing.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for an eligible request, arbitrating each cycle
// ST_BCAST | bus event on the bus for one cycle, grant asserted
// ST_SNOOP | sample snooper shared/abort (source's own response masked)
// ST_WB    | write-back of the Modified copy, until mem_ack
// ST_MEM   | memory fill read, until mem_ack
// ST_DONE  | completion pulse to the requester, pointer advanced
module mesi_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  output logic [N_REQ-1:0]           gnt,
  output logic                       bus_valid,
  output logic [4:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [$clog2(N_REQ)-1:0]   bus_src,
  input  logic [N_REQ-1:0]           snoop_shared,
  input  logic [N_REQ-1:0]           snoop_abort,
  output logic                       mem_req,
  output logic                       mem_we,
  input  logic                       mem_ack,
  output logic [N_REQ-1:0]           done,
  output logic                       done_shared
);

  localparam int IW = $clog2(N_REQ);

  bus_state_t          state;
  logic [IW-1:0]       ptr;
  logic [1:0]          op_q;
  logic                sh_q;
  logic                ab_q;

  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sh_now;
  logic                ab_now;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (arb_gnt),
    .index    (arb_idx)
  );

  // Eligibility and the op/address of whichever requester the arbiter picks.
  always_comb begin
    eligible = '0;
    sel_op   = OP_NONE;
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req[i] && (req_op[2*i +: 2] != OP_NONE);
      if (arb_gnt[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // gnt is one-hot of the source while in SNOOP, so it doubles as the self-mask.
  always_comb begin
    sh_now = |(snoop_shared & ~gnt);
    ab_now = |(snoop_abort & ~gnt);
  end

  // Sequencer: state, latched transaction fields and registered outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state       <= ST_IDLE;
      ptr         <= IW'(N_REQ - 1);
      op_q        <= OP_NONE;
      sh_q        <= 1'b0;
      ab_q        <= 1'b0;
      gnt         <= '0;
      bus_valid   <= 1'b0;
      bus_op      <= EV_NONE;
      bus_addr    <= '0;
      bus_src     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      done        <= '0;
      done_shared <= 1'b0;
    end else begin
      bus_valid   <= 1'b0;
      done        <= '0;
      done_shared <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            op_q      <= sel_op;
            bus_addr  <= sel_addr;
            bus_src   <= arb_idx;
            gnt       <= arb_gnt;
            bus_valid <= 1'b1;
            bus_op    <= op_to_event(sel_op);
            state     <= ST_BCAST;
          end
        end
        ST_BCAST: begin
          bus_op <= EV_NONE;
          state  <= ST_SNOOP;
        end
        ST_SNOOP: begin
          sh_q <= sh_now;
          ab_q <= ab_now;
          if (op_q == OP_INV) begin
            done  <= gnt;
            state <= ST_DONE;
          end else if (ab_now) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            state   <= ST_WB;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            state   <= ST_MEM;
          end
        end
        ST_WB: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            state  <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            done        <= gnt;
            done_shared <= (op_q == OP_RM) && (sh_q || ab_q);
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt   <= '0;
          ptr   <= bus_src;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Scoreboard bench for mesi_bus_ctrl: transaction-level model predicts grant order and results.
module tb_mesi_bus_ctrl;

  localparam int N  = 4;
  localparam int A  = 8;
  localparam int IW = 2;

  logic              CLK, CLR;
  logic [N-1:0]      req;
  logic [2*N-1:0]    req_op;
  logic [N*A-1:0]    req_addr;
  logic [N-1:0]      gnt;
  logic              bus_valid;
  logic [4:0]        bus_op;
  logic [A-1:0]      bus_addr;
  logic [IW-1:0]     bus_src;
  logic [N-1:0]      snoop_shared, snoop_abort;
  logic              mem_req, mem_we, mem_ack;
  logic [N-1:0]      done;
  logic              done_shared;

  mesi_bus_ctrl #(.N_REQ(N), .ADDR_W(A)) dut (
    .CLK(CLK), .CLR(CLR), .req(req), .req_op(req_op), .req_addr(req_addr),
    .gnt(gnt), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_src(bus_src), .snoop_shared(snoop_shared), .snoop_abort(snoop_abort),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .done(done), .done_shared(done_shared)
  );

  typedef struct {
    int         src;
    logic [4:0] ev;
    logic [A-1:0] addr;
    bit         wb;
    bit         ds;
    bit         inv;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] snp_sh_q[$];
  logic [N-1:0] snp_ab_q[$];

  int n_chk = 0, n_pass = 0;
  int n_done = 0;
  int m_ptr = N - 1;
  int wb_acks = 0, fill_acks = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    $display("FAIL %s: event not predicted by model", name);
  endtask

  function automatic logic [31:0] outs();
    return 32'({gnt, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we, done, done_shared});
  endfunction

  // Memory: acknowledges after 0..2 wait cycles, plus stray acks while idle.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge CLK);
      if (CLR) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) wb_acks++;
          else fill_acks++;
          wcnt = $urandom_range(0, 2);
        end else begin
          wcnt--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 5) == 0);
      end
    end
  end

  // Snoopers: planned responses in the SNOOP cycle, noise otherwise.
  initial begin
    bit arm;
    arm = 1'b0;
    snoop_shared = '0;
    snoop_abort = '0;
    forever begin
      @(negedge CLK);
      if (CLR) begin
        arm = 1'b0;
        snoop_shared = N'($urandom);
        snoop_abort = N'($urandom);
      end else if (arm) begin
        arm = 1'b0;
        if (snp_sh_q.size() > 0) begin
          snoop_shared = snp_sh_q.pop_front();
          snoop_abort = snp_ab_q.pop_front();
        end
      end else begin
        snoop_shared = N'($urandom);
        snoop_abort = N'($urandom);
        if (bus_valid) arm = 1'b1;
      end
    end
  end

  // Monitor: pops the expected transaction at broadcast, checks it at completion.
  initial begin
    int cyc, t0, mr, wb0, fill0;
    bit act;
    exp_t cur;
    cyc = 0; t0 = 0; mr = 0; wb0 = 0; fill0 = 0; act = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (CLR) begin
        act = 1'b0;
        continue;
      end
      if (bus_valid) begin
        if (exp_q.size() == 0 || act) begin
          fail_evt("unexpected_bcast");
        end else begin
          cur = exp_q.pop_front();
          act = 1'b1;
          t0 = cyc;
          mr = 0;
          wb0 = wb_acks;
          fill0 = fill_acks;
          chk("bcast_gnt", 32'(gnt), 32'(1) << cur.src);
          chk("bus_op", 32'(bus_op), 32'(cur.ev));
          chk("bus_addr", 32'(bus_addr), 32'(cur.addr));
          chk("bus_src", 32'(bus_src), 32'(cur.src));
        end
      end
      if (mem_req) begin
        if (act) mr++;
        else fail_evt("unexpected_mem_req");
      end
      if (|done) begin
        if (!act) begin
          fail_evt("unexpected_done");
        end else begin
          chk("done_onehot", 32'(done), 32'(1) << cur.src);
          chk("done_shared", 32'(done_shared), 32'(cur.ds));
          chk("done_gnt", 32'(gnt), 32'(1) << cur.src);
          chk("wb_count", 32'(wb_acks - wb0), 32'(cur.wb));
          chk("fill_count", 32'(fill_acks - fill0), cur.inv ? 32'd0 : 32'd1);
          chk("latency", 32'(cyc - t0), 32'(2 + mr));
          act = 1'b0;
          n_done++;
        end
      end
    end
  end

  // Raise a set of requests; the model predicts RR service order and outcomes.
  task automatic run_burst(input logic [N-1:0] r, input logic [2*N-1:0] ops,
                           input logic [N*A-1:0] addrs, input bit rnd,
                           input logic [N-1:0] fsh, input logic [N-1:0] fab);
    logic [N-1:0] pend, sv, av;
    logic [1:0] op;
    int p, j, target;
    bit sh, ab;
    exp_t e;
    req_op = ops;
    req_addr = addrs;
    req = r;
    pend = '0;
    target = n_done;
    for (int i = 0; i < N; i++) begin
      pend[i] = r[i] && (ops[2*i +: 2] != 2'b00);
      if (pend[i]) target++;
    end
    p = m_ptr;
    while (pend != '0) begin
      j = 0;
      for (int k = 1; k <= N; k++) begin
        j = (p + k) % N;
        if (pend[j]) break;
      end
      p = j;
      pend[p] = 1'b0;
      op = ops[2*p +: 2];
      sv = rnd ? N'($urandom) : fsh;
      av = rnd ? (($urandom_range(0, 2) == 0) ? N'($urandom) : '0) : fab;
      sh = 1'b0;
      ab = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i != p) begin
          sh = sh | sv[i];
          ab = ab | av[i];
        end
      end
      e.src = p;
      e.addr = addrs[A*p +: A];
      e.inv = (op == 2'b11);
      e.ev = (op == 2'b01) ? 5'b00001 : (op == 2'b10) ? 5'b00100 : 5'b10000;
      e.wb = !e.inv && ab;
      e.ds = (op == 2'b01) && (sh || ab);
      exp_q.push_back(e);
      snp_sh_q.push_back(sv);
      snp_ab_q.push_back(av);
    end
    m_ptr = p;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (gnt[i]) begin
          req_addr[A*i +: A] = A'($urandom);
          req_op[2*i +: 2] = 2'($urandom);
        end
      end
      if (n_done >= target) break;
    end
    chk("burst_complete", 32'(n_done), 32'(target));
    if (n_done < target) begin
      exp_q.delete();
      snp_sh_q.delete();
      snp_ab_q.delete();
      n_done = target;
    end
    req = '0;
    @(negedge CLK);
  endtask

  initial begin
    logic [N*A-1:0] ad;
    logic [2*N-1:0] rop;
    exp_t e;
    CLR = 1'b0;
    req = '0;
    req_op = '0;
    req_addr = '0;
    #1 CLR = 1'b1;
    #1 chk("reset_outputs", outs(), 32'd0);
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_no_grant", 32'({gnt, bus_valid, mem_req}), 32'd0);
    end

    ad = N*A'($urandom);
    ad[A*1 +: A] = 8'h3C;
    run_burst(4'b0010, 8'b00_00_01_00, ad, 1'b0, 4'b0000, 4'b0000);
    run_burst(4'b0001, 8'b00_00_00_01, N*A'($urandom), 1'b0, 4'b0000, 4'b0100);
    run_burst(4'b1000, 8'b11_00_00_00, N*A'($urandom), 1'b0, 4'b1000, 4'b0000);
    run_burst(4'b1111, 8'b10_10_10_10, N*A'($urandom), 1'b1, 4'b0000, 4'b0000);
    run_burst(4'b0001, 8'b00_00_00_10, N*A'($urandom), 1'b1, 4'b0000, 4'b0000);

    for (int b = 0; b < 40; b++) begin
      run_burst(N'($urandom), (2*N)'($urandom), (N*A)'($urandom), 1'b1, 4'b0000, 4'b0000);
    end

    // Reset while the fill is outstanding; req[2] stays high across it.
    ad = (N*A)'($urandom);
    rop = 8'b00_01_00_00;
    req_op = rop;
    req_addr = ad;
    req = 4'b0100;
    e.src = 2; e.addr = ad[A*2 +: A]; e.inv = 1'b0; e.ev = 5'b00001; e.wb = 1'b0; e.ds = 1'b0;
    exp_q.push_back(e);
    snp_sh_q.push_back(4'b0000);
    snp_ab_q.push_back(4'b0000);
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (mem_req) break;
    end
    chk("mem_req_before_reset", 32'(mem_req), 32'd1);
    #2 CLR = 1'b1;
    #1 chk("async_reset_outputs", outs(), 32'd0);
    exp_q.delete();
    snp_sh_q.delete();
    snp_ab_q.delete();
    m_ptr = N - 1;
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    run_burst(4'b0100, rop, ad, 1'b1, 4'b0000, 4'b0000);
    run_burst(4'b0111, 8'b00_01_10_11, (N*A)'($urandom), 1'b1, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
